cpu_bus: RTL and testbench
==========================

Name: cpu_bus

Overview:
- CPU-side memory-bus responder; it answers every access the 6502 core issues on addr / d_out / write.
- Decodes the NES CPU address map: internal 2 KB RAM (mirrored), PPU register port, APU/IO register port, cartridge PRG port. Returns read data with fixed 1-cycle latency.
- Owns OAM DMA ($4014). During DMA it drives `ready` low and becomes bus master itself.

Parameters:
- RAM_AW, 11, internal RAM address width (2^RAM_AW bytes; mirrored across $0000-$1FFF).
- OAM_REG, 4, PPU register index written by DMA (OAMDATA).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (reset==0 resets on the rising clk edge)
- cpu_addr  in  16  CPU address
- cpu_dout  in  8  CPU write data
- cpu_write  in  1  CPU write strobe
- cpu_din  out  8  read data to CPU (data for the address of the previous cycle)
- cpu_ready  out  1  0 stalls CPU (DMA)
- bus_wdata  out  8  write data to all external ports
- ppu_cs  out  1  PPU register access this cycle
- ppu_reg  out  3  PPU register index (addr[2:0])
- ppu_wr  out  1  PPU write (cs && !wr is a read, side effects allowed)
- ppu_rdata  in  8  PPU read data, valid the cycle after ppu_cs
- io_cs  out  1  APU/IO access ($4000-$4017, excluding $4014)
- io_reg  out  5  addr[4:0]
- io_wr  out  1  IO write
- io_rdata  in  8  IO read data, next cycle
- prg_cs  out  1  cartridge access ($4020-$FFFF)
- prg_addr  out  16  cartridge address
- prg_wr  out  1  cartridge write
- prg_rdata  in  8  cartridge read data, next cycle
- dma_active  out  1  DMA in progress

Behaviour:
- Reset values:
  - cpu_din=0, cpu_ready=1, dma_active=0.
  - All cs/wr outputs 0, bus_wdata=0.
  - Open-bus latch=0, parity bit=0, DMA state IDLE.
  - RAM contents are not reset.
- Bus master mux:
  - IDLE: cpu_addr / cpu_dout / cpu_write drive the decoder.
  - Otherwise the DMA engine drives it and CPU inputs are ignored.
- Decode (combinational, same cycle):
  - $0000-$1FFF → RAM[addr[RAM_AW-1:0]].
  - $2000-$3FFF → PPU, reg=addr[2:0].
  - $4000-$4017 except $4014 → IO.
  - $4014 → DMA trigger on write; read is open bus.
  - $4018-$401F → unmapped.
  - $4020-$FFFF → PRG.
- Writes commit at the clk edge of the cycle in which write=1.
- Read latency:
  - Region of cycle t is registered.
  - cpu_din at cycle t+1 = RAM dout / ppu_rdata / io_rdata / prg_rdata selected by that region.
  - Unmapped region or $4014 read returns the open-bus latch.
- Open-bus latch updates every cycle:
  - with cpu_din on read cycles;
  - with the written data on write cycles.
- Parity bit toggles every clk while not in reset.
- DMA FSM:
  - IDLE → HALT on a CPU write to $4014; latch page = cpu_dout.
  - HALT: 1 cycle, no bus access.
  - HALT → ALIGN if parity==1 in HALT, else HALT → RD.
  - ALIGN: 1 cycle idle, → RD.
  - RD: address {page, idx}, read-only; → WR.
  - WR: ppu_cs=1, ppu_reg=OAM_REG, ppu_wr=1, bus_wdata = data returned for the RD address.
  - WR → RD with idx+1 if idx≠255; else → IDLE.
- DMA timing:
  - cpu_ready=0 and dma_active=1 in all non-IDLE states: 513 cycles (no ALIGN) or 514 cycles (with ALIGN).
  - cpu_ready returns to 1 on the first cycle back in IDLE.
- idx is 8 bits and ends exactly at 255; the page does not increment.
- DMA reads pass through the normal decoder, so a PPU or PRG page produces real cs strobes.
- cpu_din during DMA carries the DMA read data. The CPU is stalled, so it is don't-care to the CPU but still feeds the open-bus latch.
- A CPU $4014 write arriving while not IDLE is impossible (CPU is masked) and is ignored.
- Reset asserted mid-DMA: next cycle state is IDLE, cpu_ready=1, no further PPU writes; a partially filled OAM is accepted.

Decomposition:
- Package nes_bus_pkg:
  - region enum {R_RAM, R_PPU, R_IO, R_DMA, R_OPEN, R_PRG};
  - DMA state enum {IDLE, HALT, ALIGN, RD, WR};
  - address boundary constants ($2000, $4000, $4014, $4018, $4020);
  - decode function addr→region.
- Sub-module cpu_ram: single-port synchronous RAM with registered read, parameter RAM_AW.

Test Plan:
- Write $0005=0xAB, then read $0805 and $1805 → cpu_din=0xAB one cycle after each read (mirror).
- Read $3FFA with ppu_rdata=0x80 → that cycle ppu_cs=1, ppu_reg=2, ppu_wr=0; next cycle cpu_din=0x80.
- Preload RAM $0200-$02FF with i^0x5A; write $4014=0x02 with parity 0 in HALT → cpu_ready low exactly 513 cycles; 256 ppu_wr pulses at reg 4 with data i^0x5A, i=0..255, in order.
- Same as above, but with parity 1 in HALT → cpu_ready low 514 cycles, identical data sequence.
- Read $8000 with prg_rdata=0x5A, then read $4018 → cpu_din=0x5A both times; read $4014 → 0x5A.
- Start DMA, assert reset=0 at idx=100 → next cycle cpu_ready=1, dma_active=0, no ppu_wr thereafter; a new $4014 write after release restarts from idx 0.

Source files
------------

// File: rtl/nes_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nes_bus_pkg
// Brief   : Shared types, address-map constants and region decoder for cpu_bus
// Revision: 1.0
// ============================================================================
package nes_bus_pkg;

    typedef enum logic [2:0] {
        R_RAM,
        R_PPU,
        R_IO,
        R_DMA,
        R_OPEN,
        R_PRG
    } region_t;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        RD,
        WR
    } dma_state_t;

    localparam logic [15:0] c_PPU_BASE  = 16'h2000;
    localparam logic [15:0] c_IO_BASE   = 16'h4000;
    localparam logic [15:0] c_DMA_ADDR  = 16'h4014;
    localparam logic [15:0] c_OPEN_BASE = 16'h4018;
    localparam logic [15:0] c_PRG_BASE  = 16'h4020;

    function automatic region_t decode_region(input logic [15:0] addr);
        region_t r;
        if (addr < c_PPU_BASE)
            r = R_RAM;
        else if (addr < c_IO_BASE)
            r = R_PPU;
        else if (addr == c_DMA_ADDR)
            r = R_DMA;
        else if (addr < c_OPEN_BASE)
            r = R_IO;
        else if (addr < c_PRG_BASE)
            r = R_OPEN;
        else
            r = R_PRG;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_ram.sv
`default_nettype none
// ============================================================================
// Module  : cpu_ram
// Brief   : Single-port synchronous RAM, registered read, write-first not used
// Revision: 1.0
// ============================================================================
module cpu_ram #(
    parameter int RAM_AW = 11
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [RAM_AW-1:0] i_addr,
    input  logic [7:0]        i_wdata,
    output logic [7:0]        o_rdata
);

    logic [7:0] r_mem [0:(1<<RAM_AW)-1];
    logic [7:0] r_rdata;

    // Contents are intentionally never reset; a read during a write returns old data.
    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_addr] <= i_wdata;
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/cpu_bus.sv
`default_nettype none
// ============================================================================
// Module  : cpu_bus
// Brief   : NES CPU-side bus responder: address decode, 1-cycle read return,
//           open-bus latch and OAM DMA engine ($4014)
// Revision: 1.0
// ============================================================================
module cpu_bus
    import nes_bus_pkg::*;
#(
    parameter int          RAM_AW  = 11,
    parameter logic [2:0]  OAM_REG = 3'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_write,
    output logic [7:0]  cpu_din,
    output logic        cpu_ready,
    output logic [7:0]  bus_wdata,
    output logic        ppu_cs,
    output logic [2:0]  ppu_reg,
    output logic        ppu_wr,
    input  logic [7:0]  ppu_rdata,
    output logic        io_cs,
    output logic [4:0]  io_reg,
    output logic        io_wr,
    input  logic [7:0]  io_rdata,
    output logic        prg_cs,
    output logic [15:0] prg_addr,
    output logic        prg_wr,
    input  logic [7:0]  prg_rdata,
    output logic        dma_active
);

    dma_state_t  r_state;
    logic [7:0]  r_page;
    logic [7:0]  r_idx;
    logic        r_parity;
    region_t     r_region;
    logic [7:0]  r_open;

    logic        w_access;
    logic [15:0] w_addr;
    logic [7:0]  w_wdata;
    logic        w_write;
    region_t     w_region;
    logic        w_ram_we;
    logic        w_dma_trig;
    logic [7:0]  w_ram_rdata;

    // Bus master mux: CPU owns the bus only while the DMA engine is idle.
    always_comb begin
        w_access = reset;
        w_addr   = cpu_addr;
        w_wdata  = cpu_dout;
        w_write  = cpu_write;
        case (r_state)
            IDLE: ;
            RD: begin
                w_addr  = {r_page, r_idx};
                w_wdata = 8'h00;
                w_write = 1'b0;
            end
            WR: begin
                w_addr  = c_PPU_BASE | {13'd0, OAM_REG};
                w_wdata = cpu_din;
                w_write = 1'b1;
            end
            default: begin
                w_access = 1'b0;
                w_addr   = 16'h0000;
                w_wdata  = 8'h00;
                w_write  = 1'b0;
            end
        endcase
    end

    assign w_region   = decode_region(w_addr);
    assign w_ram_we   = w_access && w_write && (w_region == R_RAM);
    assign w_dma_trig = w_access && w_write && (w_region == R_DMA) && (r_state == IDLE);

    assign ppu_cs    = w_access && (w_region == R_PPU);
    assign ppu_reg   = w_addr[2:0];
    assign ppu_wr    = ppu_cs && w_write;
    assign io_cs     = w_access && (w_region == R_IO);
    assign io_reg    = w_addr[4:0];
    assign io_wr     = io_cs && w_write;
    assign prg_cs    = w_access && (w_region == R_PRG);
    assign prg_addr  = w_addr;
    assign prg_wr    = prg_cs && w_write;
    assign bus_wdata = w_access ? w_wdata : 8'h00;

    assign cpu_ready  = (r_state == IDLE);
    assign dma_active = (r_state != IDLE);

    cpu_ram #(
        .RAM_AW (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_addr[RAM_AW-1:0]),
        .i_wdata (w_wdata),
        .o_rdata (w_ram_rdata)
    );

    // Read return: previous cycle's region picks the source; writes return open bus.
    always_comb begin
        case (r_region)
            R_RAM:   cpu_din = w_ram_rdata;
            R_PPU:   cpu_din = ppu_rdata;
            R_IO:    cpu_din = io_rdata;
            R_PRG:   cpu_din = prg_rdata;
            default: cpu_din = r_open;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_page   <= 8'h00;
            r_idx    <= 8'h00;
            r_parity <= 1'b0;
            r_region <= R_OPEN;
            r_open   <= 8'h00;
        end else begin
            r_parity <= ~r_parity;
            r_region <= (w_access && !w_write) ? w_region : R_OPEN;
            r_open   <= (w_access && w_write) ? w_wdata : cpu_din;
            case (r_state)
                IDLE: begin
                    if (w_dma_trig) begin
                        r_state <= HALT;
                        r_page  <= cpu_dout;
                        r_idx   <= 8'h00;
                    end
                end
                HALT:  r_state <= r_parity ? ALIGN : RD;
                ALIGN: r_state <= RD;
                RD:    r_state <= WR;
                WR: begin
                    r_idx   <= r_idx + 8'd1;
                    r_state <= (r_idx == 8'hFF) ? IDLE : RD;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_bus
// Brief   : Directed + randomized self-checking bench for cpu_bus
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_cpu_bus;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_dout = 8'h00;
    logic        cpu_write = 1'b0;
    logic [7:0]  cpu_din;
    logic        cpu_ready;
    logic [7:0]  bus_wdata;
    logic        ppu_cs;
    logic [2:0]  ppu_reg;
    logic        ppu_wr;
    logic [7:0]  ppu_rdata = 8'h00;
    logic        io_cs;
    logic [4:0]  io_reg;
    logic        io_wr;
    logic [7:0]  io_rdata = 8'h00;
    logic        prg_cs;
    logic [15:0] prg_addr;
    logic        prg_wr;
    logic [7:0]  prg_rdata = 8'h00;
    logic        dma_active;

    int checks = 0;
    int failures = 0;
    logic m_par = 1'b0;

    cpu_bus #(.RAM_AW(11), .OAM_REG(3'd4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .cpu_write  (cpu_write),
        .cpu_din    (cpu_din),
        .cpu_ready  (cpu_ready),
        .bus_wdata  (bus_wdata),
        .ppu_cs     (ppu_cs),
        .ppu_reg    (ppu_reg),
        .ppu_wr     (ppu_wr),
        .ppu_rdata  (ppu_rdata),
        .io_cs      (io_cs),
        .io_reg     (io_reg),
        .io_wr      (io_wr),
        .io_rdata   (io_rdata),
        .prg_cs     (prg_cs),
        .prg_addr   (prg_addr),
        .prg_wr     (prg_wr),
        .prg_rdata  (prg_rdata),
        .dma_active (dma_active)
    );

    always #5 clk = ~clk;

    // Reference parity: cleared by reset, flips on every un-reset edge.
    always @(posedge clk) m_par <= reset ? ~m_par : 1'b0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic w);
        cpu_addr  = a;
        cpu_dout  = d;
        cpu_write = w;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_dma(input logic [7:0] page, input logic want_par, input string tag);
        int          low;
        int          nbad;
        int          first_bad;
        logic        done;
        logic [10:0] q[$];
        int          exp_len;
        exp_len = 513 + int'(want_par);
        drive(16'h0000, 8'h00, 1'b0);
        if ((!m_par) != want_par)
            next_cycle();
        drive(16'h4014, page, 1'b1);
        next_cycle();
        drive(16'h4014, 8'h00, 1'b0);
        low  = 0;
        nbad = 0;
        done = 1'b0;
        for (int c = 0; c < 700 && !done; c++) begin
            @(negedge clk);
            if (cpu_ready) begin
                done = 1'b1;
                chk({tag, "_end_dma_active"}, 32'(dma_active), 32'd0);
            end else begin
                low++;
                if (dma_active !== 1'b1) nbad++;
                if (ppu_cs && ppu_wr) q.push_back({ppu_reg, bus_wdata});
            end
            next_cycle();
        end
        chk({tag, "_finished"}, 32'(done), 32'd1);
        chk({tag, "_ready_low_cycles"}, 32'(low), 32'(exp_len));
        chk({tag, "_active_while_stalled_bad"}, 32'(nbad), 32'd0);
        chk({tag, "_oam_write_count"}, 32'(q.size()), 32'd256);
        nbad = 0;
        first_bad = -1;
        for (int i = 0; i < q.size() && i < 256; i++) begin
            if (q[i] !== {3'd4, 8'(i) ^ 8'h5A}) begin
                nbad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        chk({tag, "_oam_data_bad"}, 32'(nbad), 32'd0);
        chk({tag, "_oam_first_bad_idx"}, 32'(first_bad), 32'hFFFF_FFFF);
    endtask

    logic [7:0]  mem [0:2047];
    bit          memv [0:2047];
    int          kind;
    int          pend;
    logic [7:0]  pend_ram;
    logic [15:0] a;
    logic [7:0]  d;
    int          nw;
    logic        done;

    initial begin
        // ---------------- reset ----------------
        repeat (3) next_cycle();
        @(negedge clk);
        chk("rst_cpu_din", 32'(cpu_din), 32'h0);
        chk("rst_cpu_ready", 32'(cpu_ready), 32'h1);
        chk("rst_dma_active", 32'(dma_active), 32'h0);
        chk("rst_cs_wr", 32'({ppu_cs, ppu_wr, io_cs, io_wr, prg_cs, prg_wr}), 32'h0);
        chk("rst_bus_wdata", 32'(bus_wdata), 32'h0);
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_cpu_din", 32'(cpu_din), 32'h0);
        next_cycle();

        // ---------------- RAM mirror ----------------
        drive(16'h0005, 8'hAB, 1'b1);
        next_cycle();
        drive(16'h0805, 8'h00, 1'b0);
        next_cycle();
        drive(16'h1805, 8'h00, 1'b0);
        @(negedge clk);
        chk("mirror_0805", 32'(cpu_din), 32'hAB);
        next_cycle();
        drive(16'h0000, 8'h00, 1'b0);
        @(negedge clk);
        chk("mirror_1805", 32'(cpu_din), 32'hAB);
        next_cycle();

        // ---------------- PPU register read ----------------
        ppu_rdata = 8'h80;
        drive(16'h3FFA, 8'h00, 1'b0);
        @(negedge clk);
        chk("ppu_rd_cs_reg_wr", 32'({ppu_cs, ppu_reg, ppu_wr}), 32'({1'b1, 3'd2, 1'b0}));
        next_cycle();
        drive(16'h0000, 8'h00, 1'b0);
        @(negedge clk);
        chk("ppu_rd_data", 32'(cpu_din), 32'h80);
        next_cycle();

        // ---------------- PRG read, unmapped and $4014 open bus ----------------
        prg_rdata = 8'h5A;
        drive(16'h8000, 8'h00, 1'b0);
        @(negedge clk);
        chk("prg_rd_cs_addr", 32'({prg_cs, prg_wr, prg_addr}), 32'({1'b1, 1'b0, 16'h8000}));
        next_cycle();
        drive(16'h4018, 8'h00, 1'b0);
        @(negedge clk);
        chk("prg_rd_data", 32'(cpu_din), 32'h5A);
        chk("unmapped_no_cs", 32'({ppu_cs, io_cs, prg_cs}), 32'h0);
        next_cycle();
        prg_rdata = 8'h11;
        drive(16'h4014, 8'h00, 1'b0);
        @(negedge clk);
        chk("open_bus_4018", 32'(cpu_din), 32'h5A);
        chk("dma_reg_read_no_cs", 32'({ppu_cs, io_cs, prg_cs, dma_active}), 32'h0);
        next_cycle();
        drive(16'h0000, 8'h00, 1'b0);
        @(negedge clk);
        chk("open_bus_4014", 32'(cpu_din), 32'h5A);
        chk("dma_reg_read_no_trigger", 32'(cpu_ready), 32'h1);
        next_cycle();

        // ---------------- randomized accesses vs. byte-array model ----------------
        pend = 0;
        pend_ram = 8'h00;
        for (int it = 0; it < 120; it++) begin
            kind = int'($urandom_range(0, 4));
            d = 8'($urandom);
            ppu_rdata = 8'($urandom);
            io_rdata  = 8'($urandom);
            prg_rdata = 8'($urandom);
            case (kind)
                0: a = 16'($urandom_range(0, 16'h1FFF));
                1: a = 16'($urandom_range(0, 16'h1FFF));
                2: begin
                    a = 16'h4000 + 16'($urandom_range(0, 23));
                    if (a == 16'h4014) a = 16'h4015;
                end
                3: a = 16'($urandom_range(16'h4020, 16'hFFFF));
                default: a = 16'($urandom_range(16'h4020, 16'hFFFF));
            endcase
            drive(a, d, (kind == 0) || (kind == 4));
            @(negedge clk);
            case (pend)
                1: chk("rnd_ram_rd", 32'(cpu_din), 32'(pend_ram));
                3: chk("rnd_io_rd", 32'(cpu_din), 32'(io_rdata));
                4: chk("rnd_prg_rd", 32'(cpu_din), 32'(prg_rdata));
                default: ;
            endcase
            chk("rnd_io_cs", 32'(io_cs), 32'(kind == 2));
            chk("rnd_prg_cs", 32'(prg_cs), 32'(kind >= 3));
            chk("rnd_wr_strobes", 32'({io_wr, prg_wr, ppu_cs}), 32'({1'b0, kind == 4, 1'b0}));
            if (kind == 2) chk("rnd_io_reg", 32'(io_reg), 32'(a[4:0]));
            if (kind >= 3) chk("rnd_prg_addr", 32'(prg_addr), 32'(a));
            if (kind == 4) chk("rnd_prg_wdata", 32'(bus_wdata), 32'(d));
            pend = 0;
            if (kind == 0) begin
                mem[a[10:0]]  = d;
                memv[a[10:0]] = 1'b1;
            end else if (kind == 1 && memv[a[10:0]]) begin
                pend = 1;
                pend_ram = mem[a[10:0]];
            end else if (kind == 2 || kind == 3) begin
                pend = kind + 1;
            end
            next_cycle();
        end
        drive(16'h0000, 8'h00, 1'b0);
        io_rdata  = 8'($urandom);
        prg_rdata = 8'($urandom);
        @(negedge clk);
        case (pend)
            1: chk("rnd_ram_rd_last", 32'(cpu_din), 32'(pend_ram));
            3: chk("rnd_io_rd_last", 32'(cpu_din), 32'(io_rdata));
            4: chk("rnd_prg_rd_last", 32'(cpu_din), 32'(prg_rdata));
            default: ;
        endcase
        next_cycle();

        // ---------------- OAM DMA from page $02 ----------------
        for (int i = 0; i < 256; i++) begin
            drive(16'h0200 + 16'(i), 8'(i) ^ 8'h5A, 1'b1);
            next_cycle();
        end
        run_dma(8'h02, 1'b0, "dma_par0");
        run_dma(8'h02, 1'b1, "dma_par1");

        // ---------------- reset in the middle of a DMA ----------------
        drive(16'h4014, 8'h02, 1'b1);
        next_cycle();
        drive(16'h0000, 8'h00, 1'b0);
        nw = 0;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (ppu_cs && ppu_wr) nw++;
            if (nw == 100) done = 1'b1;
            next_cycle();
        end
        chk("rst_mid_reached_idx100", 32'(done), 32'h1);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_no_wr_in_reset", 32'(ppu_wr), 32'h0);
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", 32'(cpu_ready), 32'h1);
        chk("rst_mid_dma_active", 32'(dma_active), 32'h0);
        nw = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (ppu_cs && ppu_wr) nw++;
            next_cycle();
        end
        chk("rst_mid_no_more_oam_wr", 32'(nw), 32'h0);
        run_dma(8'h02, 1'b0, "dma_restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
